// File: rtl/vga_timing.sv
// Raster timing generator: horizontal/vertical pixel counters advanced by a pixel strobe,
// with registered sync/blanking aligned to position, plus a combinational next-position view.
module vga_timing #(
    parameter int          H_VISIBLE   = 640,
    parameter int          H_FRONT     = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BACK      = 48,
    parameter int          V_VISIBLE   = 480,
    parameter int          V_FRONT     = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter logic [31:0] FRAME_INIT  = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [9:0]  position_x,
    output logic [9:0]  position_x_NEXT,
    output logic [8:0]  position_y,
    output logic [8:0]  position_y_NEXT,
    output logic [31:0] frame,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        visible
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_n;
    logic [9:0] vc_n;
    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;
    logic       hsync_n;
    logic       vsync_n;
    logic       visible_n;

    // Sync and blanking are decoded from the next position so that once registered
    // they line up with position_x/position_y in the same cycle.
    always_comb begin
        h_wrap     = (hc == H_LAST);
        v_wrap     = (vc == V_LAST);
        hc_n       = hc;
        vc_n       = vc;
        frame_wrap = 1'b0;
        if (pix_en) begin
            hc_n = h_wrap ? 10'd0 : hc + 10'd1;
            if (h_wrap) begin
                vc_n = v_wrap ? 10'd0 : vc + 10'd1;
            end
            frame_wrap = h_wrap && v_wrap;
        end
        if (!rst) begin
            hc_n       = 10'd0;
            vc_n       = 10'd0;
            frame_wrap = 1'b0;
        end
        hsync_n   = (hc_n >= HS_FIRST && hc_n <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_n   = (vc_n >= VS_FIRST && vc_n <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        visible_n = (hc_n < H_VIS) && (vc_n < V_VIS);
    end

    // frame_start is a single-clock pulse, so it is refreshed every clock; everything
    // else only moves on a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc          <= 10'd0;
            vc          <= 10'd0;
            frame       <= FRAME_INIT;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            visible     <= 1'b1;
        end else begin
            frame_start <= frame_wrap;
            if (pix_en) begin
                hc      <= hc_n;
                vc      <= vc_n;
                hsync   <= hsync_n;
                vsync   <= vsync_n;
                visible <= visible_n;
                if (frame_wrap) begin
                    frame <= frame + 32'd1;
                end
            end
        end
    end

    // position_y deliberately exposes only 9 bits; it aliases during vertical blanking.
    assign position_x      = hc;
    assign position_y      = vc[8:0];
    assign position_x_NEXT = hc_n;
    assign position_y_NEXT = vc_n[8:0];

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the screensaver display path. It advances horizontal and vertical pixel counters on each pixel-enable strobe and drives sync, blanking and frame count. It also exports the current and next-cycle pixel position consumed directly by the image pattern stages. The image stages register colour from the `_NEXT` position, so their `r/g/b` output lines up with this block's registered `position_*`, `hsync`, `vsync` and `visible` in the same cycle.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 1'b0, asserted level of `hsync`/`vsync`

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset)
- `pix_en` in 1: pixel strobe; counters advance only when high
- `position_x` out 10: current horizontal count, registered
- `position_x_NEXT` out 10: value `position_x` takes after the next `clk` edge, combinational
- `position_y` out 9: current vertical count low 9 bits, registered
- `position_y_NEXT` out 9: value `position_y` takes after the next edge, combinational
- `frame` out 32: completed-frame counter
- `frame_start` out 1: one-cycle pulse when position becomes (0,0) from wrap
- `hsync` out 1: registered horizontal sync
- `vsync` out 1: registered vertical sync
- `visible` out 1: registered, high when inside the active area

## Operation
- `H_TOTAL` is `H_VISIBLE+H_FRONT+H_SYNC+H_BACK`. Default 800.
- `V_TOTAL` is `V_VISIBLE+V_FRONT+V_SYNC+V_BACK`. Default 525.
- The internal counters `hc` and `vc` are 10 bits each.
- `position_x = hc`. `position_y = vc[8:0]`. In vertical blanking, `position_y` aliases. Downstream logic must blank with `visible`.
- Horizontal step when `pix_en`=1: `hc_n = (hc == H_TOTAL-1) ? 0 : hc+1`.
- Vertical step: `vc` advances only when `hc` wraps. `vc_n = (vc == V_TOTAL-1) ? 0 : vc+1`.
- When `pix_en`=0: `hc_n = hc`, `vc_n = vc`, and the `_NEXT` outputs equal the current outputs.
- While `rst`=0, the `_NEXT` outputs are forced to 0.
- `hsync` is asserted (`SYNC_ACTIVE`) when `hc_n` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. Default range is [656, 751].
- `vsync` is asserted when `vc_n` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]. Default range is [490, 491].
- `visible` is `(hc_n < H_VISIBLE) && (vc_n < V_VISIBLE)`.
- `hsync`, `vsync` and `visible` are registered from `hc_n`/`vc_n`, so they align with `position_*`.
- `frame` increments by 1 on the edge where both counters wrap to 0. It wraps from 0xFFFFFFFF to 0.
- `frame_start` is registered and high for exactly one cycle on that same edge.

## Timing
- Reset values:
  - `position_x`=0, `position_y`=0, `frame`=0
  - `frame_start`=0, `visible`=1
  - `hsync`=`vsync`=~`SYNC_ACTIVE`
- Latency:
  - `_NEXT` outputs are 0-cycle, combinational from state and `pix_en`.
  - All other outputs change only on the edge where `pix_en`=1.
- With `pix_en` held high:
  - One line is 800 cycles.
  - One frame is 420000 cycles.
  - `hsync` stays asserted for 96 cycles.
  - `vsync` stays asserted for 1600 cycles.
- Reset deasserted mid-frame: the next frame restarts at (0,0) with `frame`=0. No `frame_start` pulse for that restart.
- `pix_en` may have any duty cycle. All behaviour is counted in `pix_en` strobes, not clocks.

## Test plan
- Reset, then release with `pix_en`=0 for 10 cycles:
  - Outputs hold reset values: `visible`=1, `hsync`=`vsync`=1, `frame`=0.
  - `position_x_NEXT`=0.
- `pix_en`=1 continuously:
  - `position_x` goes 0..799 then 0, and `position_y` goes 0→1 at that wrap.
  - `hsync`=0 for exactly `position_x` 656..751.
  - `visible` falls at `position_x`=640.
- Run 420000 strobes:
  - `frame` goes 0→1.
  - `frame_start` pulses once, coincident with `position_x`=`position_y`=0.
  - `vsync`=0 for lines 490..491 only.
  - `visible`=0 throughout lines 480..524, during which `position_y` reads 480..511 then 0..12.
- `pix_en` toggling every other cycle:
  - Each position persists 2 cycles.
  - `position_x_NEXT` equals `position_x` on `pix_en`=0 cycles and `position_x+1` otherwise.
- Assert `rst` at `position_x`=300, `position_y`=200:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - After release, the sequence restarts from (0,0).
- Override parameters to a small raster: H=4/1/1/1, V=3/1/1/1, totals 7×6:
  - `frame` increments every 42 strobes.
  - Sync windows are `hc`=5 and `vc`=4.
  - `frame` wraps from a forced 0xFFFFFFFF to 0.
